// File: rtl/lifo_stack.sv
// Clocked LIFO stack growing downward from DEPTH-1, with registered pop/peek ports,
// count/sp status and sticky overflow/underflow flags. Define STACK_DUMP_EN for a debug dump.
module lifo_stack #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic signed [DATA_W-1:0] push_data,
    input  logic                     pop,
    output logic signed [DATA_W-1:0] pop_data,
    output logic                     pop_valid,
    input  logic                     peek_en,
    input  logic [ADDR_W-1:0]        peek_off,
    output logic signed [DATA_W-1:0] peek_data,
    output logic                     peek_valid,
    output logic [ADDR_W:0]          count,
    output logic [ADDR_W:0]          sp,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err,
    input  logic                     dump_req
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != $clog2(DEPTH)) begin : g_bad_cfg
        $error("lifo_stack: DEPTH must be a power of two >= 4 and ADDR_W must not be overridden");
    end

    localparam logic [ADDR_W:0] DEPTH_V = DEPTH;
    localparam logic [ADDR_W:0] ONE_V   = 1;

    logic signed [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [ADDR_W:0]   sp_w;
    logic [ADDR_W:0]   push_lin;
    logic [ADDR_W:0]   peek_lin;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] peek_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic              pop_hit;
    logic              pass_thru;
    logic              peek_hit;
    logic              ovf_set;
    logic              unf_set;

    // Status is derived only from the count register, never from request inputs.
    assign sp_w     = DEPTH_V - cnt_q;
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == DEPTH_V);
    assign count    = cnt_q;
    assign sp       = sp_w;
    assign empty    = is_empty;
    assign full     = is_full;

    assign top_addr  = sp_w[ADDR_W-1:0];
    assign push_lin  = sp_w - ONE_V;
    assign push_addr = push_lin[ADDR_W-1:0];
    assign peek_lin  = sp_w + {1'b0, peek_off};
    assign peek_addr = peek_lin[ADDR_W-1:0];
    assign peek_hit  = peek_en && ({1'b0, peek_off} < cnt_q);

    always_comb begin
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_addr   = top_addr;
        pop_hit   = 1'b0;
        pass_thru = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = push_addr;
                    cnt_d   = cnt_q + ONE_V;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop_hit = 1'b1;
                    cnt_d   = cnt_q - ONE_V;
                end
            end
            2'b11: begin
                // Replace-top; an empty stack simply forwards push_data.
                if (is_empty) begin
                    pass_thru = 1'b1;
                end else begin
                    pop_hit = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
            peek_data  <= '0;
            peek_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pop_valid  <= pop_hit || pass_thru;
            peek_valid <= peek_hit;
            if (pop_hit) begin
                pop_data <= mem[top_addr];
            end else if (pass_thru) begin
                pop_data <= push_data;
            end
            if (peek_hit) begin
                peek_data <= mem[peek_addr];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= push_data;
        end
    end

`ifdef STACK_DUMP_EN
    always_ff @(posedge clk) begin
        if (dump_req) begin
            $write("lifo_stack dump: count=%0d sp=%0d\n", cnt_q, sp_w);
            if (is_empty) begin
                $write("EMPTY\n");
            end else begin
                for (int unsigned a = DEPTH; a > 32'(sp_w); a--) begin
                    $write("%0d %h %0d %h\n", a - 1, ADDR_W'(a - 1),
                           mem[ADDR_W'(a - 1)], mem[ADDR_W'(a - 1)]);
                end
            end
        end
    end
`else
    logic unused_dump_req;
    assign unused_dump_req = dump_req;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack (DEPTH=256): stimulus queues expected pop/peek
// results, a negedge monitor compares them whenever a valid pulse appears.
module tb_lifo_stack;

    localparam int DATA_W = 11;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     push;
    logic signed [DATA_W-1:0] push_data;
    logic                     pop;
    logic signed [DATA_W-1:0] pop_data;
    logic                     pop_valid;
    logic                     peek_en;
    logic [ADDR_W-1:0]        peek_off;
    logic signed [DATA_W-1:0] peek_data;
    logic                     peek_valid;
    logic [ADDR_W:0]          count;
    logic [ADDR_W:0]          sp;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;
    logic                     clr_err;
    logic                     dump_req;

    int vectors    = 0;
    int miscompares = 0;
    int pop_q[$];
    int peek_q[$];

    lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .peek_en(peek_en), .peek_off(peek_off),
        .peek_data(peek_data), .peek_valid(peek_valid), .count(count), .sp(sp),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err), .dump_req(dump_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && pop_valid) begin
            if (pop_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_valid_unexpected: got 1, expected 0 (t=%0t)", $time);
            end else begin
                chk("pop_data", pop_data, pop_q.pop_front());
            end
        end
        if (!reset && peek_valid) begin
            if (peek_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL peek_valid_unexpected: got 1, expected 0 (t=%0t)", $time);
            end else begin
                chk("peek_data", peek_data, peek_q.pop_front());
            end
        end
    end

    task automatic op(input logic p, input int d, input logic q, input logic pk,
                      input int off, input logic ce);
        @(negedge clk);
        push      = p;
        push_data = DATA_W'(d);
        pop       = q;
        peek_en   = pk;
        peek_off  = ADDR_W'(off);
        clr_err   = ce;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        peek_en = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_push(input int d);
        op(1'b1, d, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_pop(input int exp);
        pop_q.push_back(exp);
        op(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic do_swap(input int d, input int exp);
        pop_q.push_back(exp);
        op(1'b1, d, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic do_peek(input int off, input int exp);
        peek_q.push_back(exp);
        op(1'b0, 0, 1'b0, 1'b1, off, 1'b0);
    endtask

    task automatic status(input string tag, input int c, input bit f, input bit e,
                          input bit ov, input bit un);
        chk({tag, "_count"}, count, c);
        chk({tag, "_sp"}, sp, DEPTH - c);
        chk({tag, "_full"}, full, f);
        chk({tag, "_empty"}, empty, e);
        chk({tag, "_overflow"}, overflow, ov);
        chk({tag, "_underflow"}, underflow, un);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        peek_en   = 1'b0;
        peek_off  = '0;
        clr_err   = 1'b0;
        dump_req  = 1'b0;
        #2;
        status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_pop_data", pop_data, 0);
        chk("reset_pop_valid", pop_valid, 0);
        chk("reset_peek_data", peek_data, 0);
        chk("reset_peek_valid", peek_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        do_push(5);
        do_push(-3);
        do_push(100);
        status("push3", 3, 1'b0, 0, 0, 0);
        do_peek(2, 5);
        do_pop(100);
        chk("pop1_count", count, 2);

        do_swap(7, -3);
        chk("swap_count", count, 2);
        do_pop(7);
        do_pop(5);
        do_swap(9, 9);
        status("passthru", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        do_push(10);
        do_push(20);
        do_push(30);
        do_peek(2, 10);
        do_peek(0, 30);
        op(1'b0, 0, 1'b0, 1'b1, 3, 1'b0);
        chk("peek_miss_hold", peek_data, 30);
        status("peek_miss", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        peek_q.push_back(30);
        op(1'b1, 40, 1'b0, 1'b1, 0, 1'b0);
        chk("peek_push_count", count, 4);
        do_pop(40);
        do_pop(30);
        do_pop(20);
        do_pop(10);
        op(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("underflow_pop_hold", pop_data, 10);
        status("underflow", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("clr_underflow", underflow, 0);

        for (int i = 0; i < DEPTH; i++) do_push(i * 3 - 300);
        status("full", DEPTH, 1'b1, 1'b0, 1'b0, 1'b0);
        do_push(999);
        status("overflow", DEPTH, 1'b1, 1'b0, 1'b1, 1'b0);
        do_swap(500, 255 * 3 - 300);
        chk("swap_full_count", count, DEPTH);
        do_peek(255, -300);
        do_peek(0, 500);
        op(1'b1, 1, 1'b0, 1'b0, 0, 1'b1);
        chk("clr_vs_set_overflow", overflow, 1);
        op(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("clr_overflow", overflow, 0);
        do_pop(500);
        for (int i = 254; i >= 0; i--) do_pop(i * 3 - 300);
        op(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        status("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        do_push(1);
        do_push(2);
        do_push(3);
        do_pop(3);
        chk("pre_reset_pop_valid", pop_valid, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        status("async_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("async_reset_pop_valid", pop_valid, 0);
        chk("async_reset_pop_data", pop_data, 0);
        push      = 1'b1;
        push_data = DATA_W'(77);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push = 1'b0;
        chk("post_reset_push_count", count, 1);
        do_pop(77);
        status("final", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("pop_q_drained", pop_q.size(), 0);
        chk("peek_q_drained", peek_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
